// File: rtl/fetch_unit.sv
// Fetch front end: PC, program-memory stage and decode-stage instruction registers.
// Define FETCH_RAS_EN to build the return-address stack for call/ret.
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int INS_W = 20,
  parameter int RAS_DEPTH = 4,
  parameter logic [INS_W-1:0] NOP = {INS_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] jmp_loc,
  input  logic              pc_mux_sel,
  input  logic              call,
  input  logic              ret,
  input  logic              stall,
  input  logic              stall_pm,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INS_W-1:0]  imem_data,
  output logic [INS_W-1:0]  ins_pm,
  output logic [INS_W-1:0]  ins,
  output logic [ADDR_W-1:0] current_address,
  output logic              ras_full,
  output logic              ras_empty,
  output logic              ras_err
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_pm;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] ras_top;
  logic              hold;
  logic              ret_take;
  logic              redirect;

  assign hold = stall | stall_pm;

`ifdef FETCH_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [CW-1:0]     ras_cnt;
  logic [PW-1:0]     top_idx;
  logic              push;
  logic              err_q;

  assign ras_full  = (ras_cnt == CW'(RAS_DEPTH));
  assign ras_empty = (ras_cnt == '0);
  assign ras_err   = err_q;
  assign top_idx   = ras_cnt[PW-1:0] - PW'(1);
  assign ras_top   = ras_mem[top_idx];
  assign ret_take  = ret & ~ras_empty & ~hold;
  // ret has priority over a simultaneous call
  assign push      = call & pc_mux_sel & ~ret & ~hold;

  always_ff @(posedge clk) begin
    if (push && !ras_full)
      ras_mem[ras_cnt[PW-1:0]] <= current_address + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (ret_take)
        ras_cnt <= ras_cnt - CW'(1);
      else if (push && !ras_full)
        ras_cnt <= ras_cnt + CW'(1);
      if ((push && ras_full) || (ret && ras_empty && !hold))
        err_q <= 1'b1;
    end
  end
`else
  logic unused_ras;

  assign unused_ras = call ^ ret ^ (RAS_DEPTH < 2);
  assign ras_full   = 1'b0;
  assign ras_empty  = 1'b1;
  assign ras_err    = 1'b0;
  assign ras_top    = '0;
  assign ret_take   = 1'b0;
`endif

  assign redirect = ~hold & (ret_take | pc_mux_sel);

  always_comb begin
    pc_next = pc + ADDR_W'(1);
    if (!reset)
      pc_next = '0;
    else if (hold)
      pc_next = pc;
    else if (ret_take)
      pc_next = ras_top;
    else if (pc_mux_sel)
      pc_next = jmp_loc;
  end

  assign imem_addr = pc_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc              <= '0;
      pc_pm           <= '0;
      ins_pm          <= NOP;
      ins             <= NOP;
      current_address <= '0;
    end else if (!stall) begin
      if (stall_pm) begin
        ins <= NOP;
      end else begin
        pc              <= pc_next;
        pc_pm           <= pc;
        ins_pm          <= redirect ? NOP : imem_data;
        ins             <= ins_pm;
        current_address <= pc_pm;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory M[a]=a+0x100, scoreboard on ins/current_address.
// Works with or without FETCH_RAS_EN.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  jmp_loc;
  logic        pc_mux_sel;
  logic        call;
  logic        ret;
  logic        stall;
  logic        stall_pm;
  logic [7:0]  imem_addr;
  logic [19:0] imem_data;
  logic [19:0] ins_pm;
  logic [19:0] ins;
  logic [7:0]  current_address;
  logic        ras_full;
  logic        ras_empty;
  logic        ras_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [19:0] ins;
    logic [7:0]  ca;
  } exp_t;

  exp_t sb[$];

  fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .jmp_loc(jmp_loc),
    .pc_mux_sel(pc_mux_sel),
    .call(call),
    .ret(ret),
    .stall(stall),
    .stall_pm(stall_pm),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .ins_pm(ins_pm),
    .ins(ins),
    .current_address(current_address),
    .ras_full(ras_full),
    .ras_empty(ras_empty),
    .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    imem_data <= 20'(imem_addr) + 20'h100;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [19:0] ins_e, input logic [7:0] ca_e);
    exp_t e;
    sb.push_back('{ins: ins_e, ca: ca_e});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("ins", 32'(ins), 32'(e.ins));
    chk("current_address", 32'(current_address), 32'(e.ca));
  endtask

  localparam bit RAS = `ifdef FETCH_RAS_EN 1'b1 `else 1'b0 `endif ;

  initial begin
    reset = 1'b0; jmp_loc = '0; pc_mux_sel = 1'b0;
    call = 1'b0; ret = 1'b0; stall = 1'b0; stall_pm = 1'b0;
    #1;
    chk("rst_ins", 32'(ins), 0);
    chk("rst_ins_pm", 32'(ins_pm), 0);
    chk("rst_ca", 32'(current_address), 0);
    chk("rst_imem_addr", 32'(imem_addr), 0);
    chk("rst_ras_empty", 32'(ras_empty), 1);
    chk("rst_ras_full", 32'(ras_full), 0);
    chk("rst_ras_err", 32'(ras_err), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // sequential fetch after reset
    step(20'h0, 8'd0);
    chk("first_ins_pm", 32'(ins_pm), 32'h100);
    step(20'h100, 8'd0);
    step(20'h101, 8'd1);

    // jump to 8 at pc=3
    pc_mux_sel = 1'b1; jmp_loc = 8'd8;
    #1;
    chk("jmp_imem_addr", 32'(imem_addr), 8);
    step(20'h102, 8'd2);
    chk("jmp_kill_ins_pm", 32'(ins_pm), 0);
    pc_mux_sel = 1'b0;
    step(20'h0, 8'd3);
    step(20'h108, 8'd8);
    step(20'h109, 8'd9);
    step(20'h10a, 8'd10);

    // full stall, redirect attempt ignored
    stall = 1'b1;
    step(20'h10a, 8'd10);
    chk("stall_ins_pm", 32'(ins_pm), 32'h10b);
    pc_mux_sel = 1'b1; jmp_loc = 8'h50;
    #1;
    chk("stall_imem_addr", 32'(imem_addr), 12);
    step(20'h10a, 8'd10);
    stall = 1'b0; pc_mux_sel = 1'b0;
    step(20'h10b, 8'd11);

    // program-memory stall: bubbles into ins
    stall_pm = 1'b1;
    step(20'h0, 8'd11);
    chk("stall_pm_ins_pm", 32'(ins_pm), 32'h10c);
    pc_mux_sel = 1'b1; jmp_loc = 8'h50;
    #1;
    chk("stall_pm_imem_addr", 32'(imem_addr), 13);
    step(20'h0, 8'd11);
    stall_pm = 1'b0; pc_mux_sel = 1'b0;
    step(20'h10c, 8'd12);
    step(20'h10d, 8'd13);

    // wrap from 0xff to 0
    pc_mux_sel = 1'b1; jmp_loc = 8'hfd;
    step(20'h10e, 8'd14);
    pc_mux_sel = 1'b0;
    step(20'h0, 8'd15);
    step(20'h1fd, 8'hfd);
    chk("wrap_imem_addr", 32'(imem_addr), 0);
    step(20'h1fe, 8'hfe);
    step(20'h1ff, 8'hff);
    step(20'h100, 8'h00);
    step(20'h101, 8'h01);
    chk("wrap_ras_err", 32'(ras_err), 0);
    step(20'h102, 8'h02);
    step(20'h103, 8'h03);
    step(20'h104, 8'h04);
    step(20'h105, 8'h05);

    // call 0x20 from 0x05, then ret
    call = 1'b1; pc_mux_sel = 1'b1; jmp_loc = 8'h20;
    step(20'h106, 8'h06);
    call = 1'b0; pc_mux_sel = 1'b0;
    step(20'h0, 8'h07);
    step(20'h120, 8'h20);
    step(20'h121, 8'h21);
    ret = 1'b1;
    #1;
    if (RAS) begin
      chk("ret_imem_addr", 32'(imem_addr), 6);
      step(20'h122, 8'h22);
      ret = 1'b0;
      step(20'h0, 8'h23);
      step(20'h106, 8'h06);
      step(20'h107, 8'h07);
    end else begin
      chk("ret_imem_addr", 32'(imem_addr), 32'h24);
      step(20'h122, 8'h22);
      ret = 1'b0;
      step(20'h123, 8'h23);
      step(20'h124, 8'h24);
      step(20'h125, 8'h25);
    end
    chk("ret_ras_empty", 32'(ras_empty), 1);

    // five nested calls into a four-deep stack
    call = 1'b1; pc_mux_sel = 1'b1; jmp_loc = 8'h40;
    repeat (4) @(posedge clk);
    #1;
    chk("nest_ras_full", 32'(ras_full), 32'(RAS));
    chk("nest_ras_err0", 32'(ras_err), 0);
    @(posedge clk);
    #1;
    chk("nest_ras_err1", 32'(ras_err), 32'(RAS));
    chk("nest_jump_pc", 32'(imem_addr), 32'h40);
    call = 1'b0; pc_mux_sel = 1'b0;

    // reset in the middle of a stalled redirect
    stall = 1'b1; pc_mux_sel = 1'b1; jmp_loc = 8'h77;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_ins", 32'(ins), 0);
    chk("mid_rst_ins_pm", 32'(ins_pm), 0);
    chk("mid_rst_ca", 32'(current_address), 0);
    chk("mid_rst_imem_addr", 32'(imem_addr), 0);
    chk("mid_rst_ras_err", 32'(ras_err), 0);
    chk("mid_rst_ras_empty", 32'(ras_empty), 1);
    stall = 1'b0; pc_mux_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // ret on empty stack: no redirect
    ret = 1'b1;
    step(20'h0, 8'd0);
    chk("empty_ret_err", 32'(ras_err), 32'(RAS));
    ret = 1'b0;
    step(20'h100, 8'd0);
    step(20'h101, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
